ascon_ctrl_fsm: RTL and testbench

- Sequencing FSM for the Ascon-128 round datapath `permutation_finale`.
- Generates the round counter, state-select, XOR enables, register enable and cipher/tag capture strobes for one full encryption: init p12, associated data p6, plaintext p6, final p12.
- Sits between the top-level I/O handshake and the datapath. One 64-bit data block is consumed per data phase.

---
 rtl/ascon_pack.sv | 9 +
 rtl/ascon_round_counter.sv | 22 ++
 rtl/ascon_ctrl_fsm.sv | 97 +++++++++
 tb/tb_ascon_ctrl_fsm.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// ascon_pack: shared state encoding and round-counter constants for the Ascon control FSM
package ascon_pack;
  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_WAIT_AD, ST_AD, ST_WAIT_PT, ST_PT, ST_FINAL, ST_DONE
  } state_ctrl_t;
  localparam logic [3:0] ROUND_START_A = 4'd0;
  localparam logic [3:0] ROUND_START_B = 4'd6;
  localparam logic [3:0] ROUND_LAST    = 4'd11;
endpackage

// File: rtl/ascon_round_counter.sv
// ascon_round_counter: loadable 4-bit round counter with last-round flag
// Ports: clock_i/resetb_i (async active-low), load_i/load_val_i load, en_i increment,
//        cnt_o current round index, last_o high when cnt_o is the final round (11).
module ascon_round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] cnt_o,
  output logic       last_o
);
  logic [3:0] cnt_q;
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i) cnt_q <= cnt_q + 4'd1;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == ROUND_LAST;
endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: sequencing FSM for one Ascon-128 encryption (init p12, AD p6, PT p6, final p12)
// Ports: clock_i/resetb_i (async active-low); start_i, data_valid_i, data_last_i handshake in;
//        data_ready_o, counter_o, data_sel_o, en_xor_*_o, en_reg_state_o, en_cipher_o,
//        en_tag_o, cipher_valid_o, busy_o, done_o to the datapath / top level.
// Build option: define ASCON_MULTI_AD_EN to accept several AD blocks (last one flagged by data_last_i).
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [3:0] counter_o,
  output logic       data_sel_o,
  output logic       en_xor_data_o,
  output logic       en_xor_key_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       en_reg_state_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
  state_ctrl_t state_q, state_d;
  logic        cipher_valid_q;
  logic        last, accept, active, first, ad_final, load;
  logic [3:0]  load_val;
`ifdef ASCON_MULTI_AD_EN
  logic        ad_last_q;
  assign ad_final = ad_last_q;
`else
  assign ad_final = 1'b1;
`endif
  assign data_ready_o = state_q == ST_WAIT_AD || state_q == ST_WAIT_PT;
  assign accept       = data_ready_o && data_valid_i;
  assign active       = state_q inside {ST_INIT, ST_AD, ST_PT, ST_FINAL};
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start_i ? ST_INIT : state_q;
      ST_INIT:          state_d = last ? ST_WAIT_AD : state_q;
      ST_WAIT_AD:       state_d = accept ? ST_AD : state_q;
      ST_AD:            state_d = last ? (ad_final ? ST_WAIT_PT : ST_WAIT_AD) : state_q;
      ST_WAIT_PT:       state_d = accept ? (data_last_i ? ST_FINAL : ST_PT) : state_q;
      ST_PT:            state_d = last ? ST_WAIT_PT : state_q;
      ST_FINAL:         state_d = last ? ST_DONE : state_q;
      default:          state_d = ST_IDLE;
    endcase
  end
  // Counter is (re)loaded only when entering a phase whose start value differs from
  // where it stands; WAIT->AD/PT keeps the START_B preset loaded on entering WAIT.
  assign load     = state_d != state_q && state_d inside {ST_INIT, ST_FINAL, ST_WAIT_AD, ST_WAIT_PT};
  assign load_val = (state_d == ST_INIT || state_d == ST_FINAL) ? START_A : START_B;
  ascon_round_counter u_cnt (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (load),
    .load_val_i (load_val),
    .en_i       (active && !last),
    .cnt_o      (counter_o),
    .last_o     (last)
  );
  assign first = counter_o == ((state_q == ST_INIT || state_q == ST_FINAL) ? START_A : START_B);
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      state_q        <= ST_IDLE;
      cipher_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cipher_valid_q <= en_cipher_o;
    end
`ifdef ASCON_MULTI_AD_EN
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) ad_last_q <= 1'b0;
    else if (accept && state_q == ST_WAIT_AD) ad_last_q <= data_last_i;
`endif
  assign en_reg_state_o   = active;
  assign data_sel_o       = active && !(state_q == ST_INIT && first);
  assign en_xor_data_o    = state_q inside {ST_AD, ST_PT, ST_FINAL} && first;
  assign en_cipher_o      = state_q inside {ST_PT, ST_FINAL} && first;
  assign en_xor_key_o     = state_q == ST_FINAL && first;
  assign en_xor_key_end_o = state_q inside {ST_INIT, ST_FINAL} && last;
  assign en_xor_lsb_o     = state_q == ST_AD && last && ad_final;
  assign en_tag_o         = state_q == ST_FINAL && last;
  assign cipher_valid_o   = cipher_valid_q;
  assign busy_o           = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign done_o           = state_q == ST_DONE;
endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm: table-driven, scoreboard-checked bench for the Ascon control FSM
module tb_ascon_ctrl_fsm;
`ifdef ASCON_MULTI_AD_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  localparam int K_IDLE = 0, K_INIT = 1, K_WAD = 2, K_AD = 3, K_WPT = 4, K_PT = 5, K_FIN = 6, K_DONE = 7;
  typedef struct packed {
    logic        s;
    logic        v;
    logic        l;
    logic [15:0] e;
  } vec_t;
  logic clk, resetb_i, start_i, data_valid_i, data_last_i;
  logic data_ready_o, data_sel_o, en_xor_data_o, en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o;
  logic en_reg_state_o, en_cipher_o, en_tag_o, cipher_valid_o, busy_o, done_o;
  logic [3:0] counter_o;
  logic [15:0] got;
  vec_t vecs[$];
  logic [15:0] exp_q[$];
  int passed = 0, total = 0;
  bit pc;
  ascon_ctrl_fsm dut (
    .clock_i(clk), .resetb_i(resetb_i), .start_i(start_i), .data_valid_i(data_valid_i),
    .data_last_i(data_last_i), .data_ready_o(data_ready_o), .counter_o(counter_o),
    .data_sel_o(data_sel_o), .en_xor_data_o(en_xor_data_o), .en_xor_key_o(en_xor_key_o),
    .en_xor_key_end_o(en_xor_key_end_o), .en_xor_lsb_o(en_xor_lsb_o),
    .en_reg_state_o(en_reg_state_o), .en_cipher_o(en_cipher_o), .en_tag_o(en_tag_o),
    .cipher_valid_o(cipher_valid_o), .busy_o(busy_o), .done_o(done_o)
  );
  assign got = {data_ready_o, counter_o, data_sel_o, en_xor_data_o, en_xor_key_o, en_xor_key_end_o,
                en_xor_lsb_o, en_reg_state_o, en_cipher_o, en_tag_o, cipher_valid_o, busy_o, done_o};
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end
  function automatic logic [15:0] expv(int k, logic [3:0] c, bit first, bit last, bit lsb, bit cv);
    bit act = k == K_INIT || k == K_AD || k == K_PT || k == K_FIN;
    return {k == K_WAD || k == K_WPT, c, act && !(k == K_INIT && first),
            (k == K_AD || k == K_PT || k == K_FIN) && first, k == K_FIN && first,
            (k == K_INIT || k == K_FIN) && last, k == K_AD && last && lsb, act,
            (k == K_PT || k == K_FIN) && first, k == K_FIN && last, cv,
            !(k == K_IDLE || k == K_DONE), k == K_DONE};
  endfunction
  task automatic add(int k, logic [3:0] c, bit first, bit last, bit lsb, logic s, logic v, logic l);
    logic [15:0] e = expv(k, c, first, last, lsb, pc);
    vecs.push_back('{s, v, l, e});
    pc = (k == K_PT || k == K_FIN) && first;
  endtask
  task automatic phase(int k, int n, int c0, bit lsb, int stray);
    for (int i = 0; i < n; i++)
      add(k, 4'(c0 + i), i == 0, c0 + i == 11, lsb, i == stray, i == stray, 1'b0);
  endtask
  task automatic seq_full(bit from_done, int fin_n);
    if (from_done) add(K_DONE, 4'd11, 0, 0, 0, 1, 0, 0);
    else add(K_IDLE, 4'd0, 0, 0, 0, 1, 0, 0);
    phase(K_INIT, 12, 0, 0, 3);
    add(K_WAD, 4'd6, 0, 0, 0, 0, 0, 1);
    add(K_WAD, 4'd6, 0, 0, 0, 0, 1, MULTI);
    phase(K_AD, 6, 6, 1, -1);
    add(K_WPT, 4'd6, 0, 0, 0, 0, 1, 0);
    phase(K_PT, 6, 6, 0, 2);
    add(K_WPT, 4'd6, 0, 0, 0, 0, 0, 0);
    add(K_WPT, 4'd6, 0, 0, 0, 0, 1, 1);
    phase(K_FIN, fin_n, 0, 0, -1);
    if (fin_n == 12) begin
      add(K_DONE, 4'd11, 0, 0, 0, 0, 0, 0);
      add(K_DONE, 4'd11, 0, 0, 0, 0, 0, 0);
    end
  endtask
  task automatic check(string name, logic [15:0] g, logic [15:0] e);
    total++;
    if (g === e) passed++;
    else $display("FAIL %s got=%h exp=%h", name, g, e);
  endtask
  task automatic run_vecs(string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      start_i = vecs[i].s;
      data_valid_i = vecs[i].v;
      data_last_i = vecs[i].l;
      exp_q.push_back(vecs[i].e);
      #1 check($sformatf("%s_vec%0d", tag, i), got, exp_q.pop_front());
    end
    vecs.delete();
  endtask
  initial begin
    resetb_i = 1'b0;
    start_i = 1'b0;
    data_valid_i = 1'b0;
    data_last_i = 1'b0;
    pc = 1'b0;
    #50 check("reset_state", got, 16'h0);
    #55 resetb_i = 1'b1;
    seq_full(1'b0, 12);
    run_vecs("full");
    seq_full(1'b1, 6);
    run_vecs("abort");
    #2 resetb_i = 1'b0;
    #1 check("async_reset", got, 16'h0);
    @(posedge clk);
    #1 check("reset_hold", got, 16'h0);
    @(negedge clk);
    resetb_i = 1'b1;
    pc = 1'b0;
    seq_full(1'b0, 12);
    run_vecs("restart");
    if (MULTI) begin
      add(K_DONE, 4'd11, 0, 0, 0, 1, 0, 0);
      phase(K_INIT, 12, 0, 0, -1);
      for (int b = 0; b < 3; b++) begin
        add(K_WAD, 4'd6, 0, 0, 0, 0, 1, b == 2);
        phase(K_AD, 6, 6, b == 2, -1);
      end
      add(K_WPT, 4'd6, 0, 0, 0, 0, 1, 1);
      phase(K_FIN, 12, 0, 0, -1);
      add(K_DONE, 4'd11, 0, 0, 0, 0, 0, 0);
      run_vecs("multi_ad");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
